// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: funct3 codes and FSM state encodings shared by the ALU sequencer
package alu_seq_pkg;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_EXEC2 = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
endpackage

// File: rtl/alu_seq_shift.sv
// alu_seq_shift: one-bit right-shift step, or a full barrel shifter when ALU_SEQ_BARREL_SHIFT_EN is defined
`ifdef ALU_SEQ_BARREL_SHIFT_EN
module alu_seq_shift #(
  parameter int XLEN = 32,
  parameter int SHW = 5
) (
  input  logic [XLEN-1:0] data,
  input  logic [SHW-1:0]  amt,
  input  logic            left,
  input  logic            arith,
  output logic [XLEN-1:0] y
);
  logic signed [XLEN-1:0] sra;
  assign sra = $signed(data) >>> amt;
  assign y = left ? data << amt : arith ? sra : data >> amt;
endmodule
`else
module alu_seq_shift #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic            arith,
  output logic [XLEN-1:0] y
);
  logic signed [XLEN-1:0] sra;
  assign sra = $signed(data) >>> 1;
  assign y = arith ? sra : data >> 1;
endmodule
`endif

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle RV32I op sequencer around an external ADD/XOR/OR/AND ALU
// ALU_SEQ_BARREL_SHIFT_EN makes every shift complete in a single pass
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic            req_alt,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [2:0]      alu_funct3,
  input  logic [XLEN-1:0] alu_out
);
`ifdef ALU_SEQ_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif
  logic [2:0] state, f3;
  logic alt, m1, m2, is_shift, is_sub, ex, sl, lt;
  logic [XLEN-1:0] acc, op2, shf, step, res;
  logic [SHW-1:0] cnt;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
  alu_seq_shift #(.XLEN(XLEN), .SHW(SHW)) u_shift (
    .data(req_op1), .amt(req_op2[SHW-1:0]), .left(req_funct3 == F3_SLL), .arith(req_alt), .y(shf)
  );
`else
  alu_seq_shift #(.XLEN(XLEN)) u_shift (.data(acc), .arith(alt), .y(shf));
`endif
  assign req_ready = state == S_IDLE;
  // SLT/SLTU reuse the SUB passes; differing operand signs decide the compare without the diff
  always_comb begin
    is_shift = f3 == F3_SLL || f3 == F3_SR;
    is_sub = (f3 == F3_ADD && alt) || f3 == F3_SLT || f3 == F3_SLTU;
    ex = state == S_EXEC && !is_shift;
    sl = (state == S_EXEC || state == S_SHIFT) && f3 == F3_SLL && cnt != '0;
    alu_in1 = (ex || state == S_EXEC2 || sl) ? acc : '0;
    alu_in2 = ex ? (is_sub ? ~op2 : op2) : state == S_EXEC2 ? XLEN'(1) : sl ? acc : '0;
    alu_funct3 = (ex && !is_sub) ? f3 : F3_ADD;
    step = f3 == F3_SLL ? alu_out : shf;
    lt = (m1 ^ m2) ? (f3 == F3_SLT ? m1 : m2) : alu_out[XLEN-1];
    res = is_shift ? (cnt == '0 ? acc : step) : (state == S_EXEC2 && f3 != F3_ADD) ? XLEN'(lt) : alu_out;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      f3 <= F3_ADD;
      alt <= 1'b0;
      m1 <= 1'b0;
      m2 <= 1'b0;
      acc <= '0;
      op2 <= '0;
      cnt <= '0;
      resp_valid <= 1'b0;
      resp_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          f3 <= req_funct3;
          alt <= req_alt;
          op2 <= req_op2;
          m1 <= req_op1[XLEN-1];
          m2 <= req_op2[XLEN-1];
          acc <= (BARREL && (req_funct3 == F3_SLL || req_funct3 == F3_SR)) ? shf : req_op1;
          cnt <= BARREL ? '0 : req_op2[SHW-1:0];
          state <= S_EXEC;
        end
        S_EXEC, S_EXEC2, S_SHIFT:
          if (state == S_EXEC && is_sub) begin
            acc <= alu_out;
            state <= S_EXEC2;
          end else if (is_shift && cnt > SHW'(1)) begin
            acc <= step;
            cnt <= cnt - SHW'(1);
            state <= S_SHIFT;
          end else begin
            resp_data <= res;
            resp_valid <= 1'b1;
            state <= S_DONE;
          end
        S_DONE: if (resp_ready) begin
          resp_valid <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed vector table plus handshake, pass-sequence and reset-abort sequences
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_alt = 1'b0, resp_ready = 1'b0;
  logic [2:0] req_funct3 = 3'b000;
  logic [31:0] req_op1 = '0, req_op2 = '0;
  logic req_ready, resp_valid;
  logic [31:0] resp_data, alu_in1, alu_in2, alu_out;
  logic [2:0] alu_funct3;
  int checks = 0, failures = 0;
  typedef struct {
    logic [2:0] f3;
    logic alt;
    logic [31:0] a, b, exp;
    int n;
  } vec_t;
  vec_t v[19];

  alu_seq_ctrl #(.XLEN(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_alt(req_alt), .req_op1(req_op1), .req_op2(req_op2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_funct3(alu_funct3), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  always_comb
    alu_out = alu_funct3 == 3'b000 ? alu_in1 + alu_in2 :
              alu_funct3 == 3'b100 ? alu_in1 ^ alu_in2 :
              alu_funct3 == 3'b110 ? alu_in1 | alu_in2 :
              alu_funct3 == 3'b111 ? alu_in1 & alu_in2 : 32'hDEAD_0BAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int sh_n(input int s);
    return BARREL ? 1 : (s == 0 ? 1 : s);
  endfunction

  task automatic issue(input logic [2:0] f3, input logic alt, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_funct3 = f3;
    req_alt = alt;
    req_op1 = a;
    req_op2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    v[0]  = '{F3_ADD,  1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1};
    v[1]  = '{F3_XOR,  1'b0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1};
    v[2]  = '{F3_OR,   1'b0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1};
    v[3]  = '{F3_AND,  1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1};
    v[4]  = '{F3_XOR,  1'b1, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1};
    v[5]  = '{F3_ADD,  1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 2};
    v[6]  = '{F3_ADD,  1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 2};
    v[7]  = '{F3_SLT,  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 2};
    v[8]  = '{F3_SLTU, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 2};
    v[9]  = '{F3_SLTU, 1'b0, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 2};
    v[10] = '{F3_SLT,  1'b0, 32'h0000_0002, 32'h0000_0007, 32'h0000_0001, 2};
    v[11] = '{F3_SLT,  1'b0, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000, 2};
    v[12] = '{F3_SLTU, 1'b0, 32'h0000_0005, 32'h8000_0000, 32'h0000_0001, 2};
    v[13] = '{F3_SLL,  1'b0, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, sh_n(31)};
    v[14] = '{F3_SLL,  1'b0, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, sh_n(1)};
    v[15] = '{F3_SR,   1'b1, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, sh_n(4)};
    v[16] = '{F3_SR,   1'b0, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, sh_n(4)};
    v[17] = '{F3_SR,   1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, sh_n(0)};
    v[18] = '{F3_SR,   1'b1, 32'h0000_0007, 32'hFFFF_FFE2, 32'h0000_0001, sh_n(2)};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_in2", alu_in2, 32'd0);
    chk("rst_alu_funct3", {29'b0, alu_funct3}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 19; i++) begin
      chk($sformatf("vec%0d_ready", i), {31'b0, req_ready}, 32'd1);
      issue(v[i].f3, v[i].alt, v[i].a, v[i].b);
      wait_resp(n);
      chk($sformatf("vec%0d_data", i), resp_data, v[i].exp);
      chk($sformatf("vec%0d_latency", i), n, v[i].n);
      chk($sformatf("vec%0d_idle_alu", i), alu_in1 | alu_in2 | {29'b0, alu_funct3}, 32'd0);
      ack();
      chk($sformatf("vec%0d_valid_clr", i), {31'b0, resp_valid}, 32'd0);
    end
    issue(F3_ADD, 1'b1, 32'd5, 32'd7);
    chk("sub_p1_funct3", {29'b0, alu_funct3}, 32'd0);
    chk("sub_p1_in1", alu_in1, 32'd5);
    chk("sub_p1_in2", alu_in2, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    chk("sub_p2_funct3", {29'b0, alu_funct3}, 32'd0);
    chk("sub_p2_in2", alu_in2, 32'd1);
    chk("sub_p2_in1", alu_in1, 32'hFFFF_FFFD);
    @(posedge clk); #1;
    chk("sub_valid", {31'b0, resp_valid}, 32'd1);
    chk("sub_data", resp_data, 32'hFFFF_FFFE);
    ack();
    issue(F3_ADD, 1'b0, 32'd1, 32'd1);
    wait_resp(n);
    req_valid = 1'b1;
    req_funct3 = F3_XOR;
    req_alt = 1'b0;
    req_op1 = 32'h0000_000F;
    req_op2 = 32'h0000_0003;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_data", resp_data, 32'd2);
      chk("bp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp_hs_valid", {31'b0, resp_valid}, 32'd0);
    chk("bp_hs_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_accept", {31'b0, req_ready}, 32'd0);
    wait_resp(n);
    chk("bp_next_latency", n, 32'd1);
    chk("bp_next_data", resp_data, 32'h0000_000C);
    ack();
    issue(F3_SLL, 1'b0, 32'd1, 32'd20);
    repeat (BARREL ? 0 : 5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", {31'b0, resp_valid}, 32'd0);
    chk("abort_data", resp_data, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_alu_in1", alu_in1, 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= resp_valid;
    end
    chk("abort_no_resp", {31'b0, seen}, 32'd0);
    issue(F3_ADD, 1'b0, 32'd2, 32'd3);
    wait_resp(n);
    chk("recover_data", resp_data, 32'd5);
    chk("recover_latency", n, 32'd1);
    ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
